// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, complex sample type, bit-reversal helper.
package fft_pkg;

    localparam int unsigned LOG2N_DEF = 5;
    localparam int unsigned WR_DEF    = 10;
    localparam int unsigned WI_DEF    = 8;
    localparam int unsigned LOG2N_MAX = 10;

    typedef struct packed {
        logic signed [WR_DEF-1:0] re;
        logic signed [WI_DEF-1:0] im;
    } cplx_t;

    // Reverse the low nbits bits of value; upper bits of the result are zero.
    function automatic logic [LOG2N_MAX-1:0] bitrev(input logic [LOG2N_MAX-1:0] value,
                                                    input int unsigned nbits);
        logic [LOG2N_MAX-1:0] v;
        logic [LOG2N_MAX-1:0] r;
        v = value;
        r = '0;
        for (int unsigned i = 0; i < LOG2N_MAX; i++) begin
            if (i < nbits) begin
                r = {r[LOG2N_MAX-2:0], v[0]};
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One reorder bank: N-entry register array, one write port, one combinational
// read port and a frame-full flag.
module fft_reorder_bank
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N = LOG2N_DEF,
    parameter int unsigned W     = WR_DEF + WI_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [LOG2N-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic             set_full,
    input  logic             clr_full,
    input  logic [LOG2N-1:0] raddr,
    output logic [W-1:0]     rdata_c,
    output logic             full
);

    localparam int unsigned N = 1 << LOG2N;

    logic [W-1:0] mem [N];

    // Sample storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

    // Full flag: set by the writer on a frame's last sample, cleared by the reader.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
        end else if (set_full) begin
            full <= 1'b1;
        end else if (clr_full) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_reorder_buffer.sv
// Ping-pong reorder buffer: writes frames in bit-reversed (or natural) address
// order and streams them out in natural order with a valid/ready handshake.
module fft_reorder_buffer
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N = LOG2N_DEF,
    parameter int unsigned WR    = WR_DEF,
    parameter int unsigned WI    = WI_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sop,
    input  logic signed [WR-1:0] in_r,
    input  logic signed [WI-1:0] in_i,
    input  logic                 bypass,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic signed [WR-1:0] out_r,
    output logic signed [WI-1:0] out_i,
    output logic                 err_sync
);

    localparam int unsigned N = 1 << LOG2N;
    localparam int unsigned W = WR + WI;
    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] CNT_PEN  = LOG2N'(N - 2);

    typedef enum logic {R_IDLE, R_STREAM} rd_state_t;

    logic [LOG2N-1:0] wr_cnt;
    logic             wr_bank;
    logic             bypass_lat;
    logic [1:0]       full;

    rd_state_t        rd_state;
    logic [LOG2N-1:0] rd_cnt;
    logic             rd_bank;

    logic             accept_c;
    logic             resync_c;
    logic             start_c;
    logic             byp_c;
    logic [LOG2N-1:0] cnt_c;
    logic [LOG2N-1:0] waddr_c;
    logic             wlast_c;
    logic [LOG2N-1:0] raddr_c;
    logic             drain_c;
    logic [W-1:0]     rdata0_c;
    logic [W-1:0]     rdata1_c;
    logic [W-1:0]     rd_word_c;

    assign in_ready = !full[wr_bank];

    // Write-side decode: accept, resync, address selection, frame completion.
    always_comb begin
        accept_c = in_valid && in_ready;
        resync_c = accept_c && in_sop && (wr_cnt != '0);
        start_c  = accept_c && ((wr_cnt == '0) || in_sop);
        byp_c    = start_c ? bypass : bypass_lat;
        cnt_c    = resync_c ? '0 : wr_cnt;
        waddr_c  = byp_c ? cnt_c : LOG2N'(bitrev(LOG2N_MAX'(cnt_c), LOG2N));
        wlast_c  = accept_c && !resync_c && (wr_cnt == CNT_LAST);
    end

    // Write counter, bank pointer, bypass latch and resync pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt     <= '0;
            wr_bank    <= 1'b0;
            bypass_lat <= 1'b0;
            err_sync   <= 1'b0;
        end else begin
            err_sync <= resync_c;
            if (accept_c) begin
                if (start_c) begin
                    bypass_lat <= bypass;
                end
                if (resync_c) begin
                    wr_cnt <= LOG2N'(1);
                end else if (wr_cnt == CNT_LAST) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + LOG2N'(1);
                end
            end
        end
    end

    // Read-side decode. A bank is released once its last entry has been loaded
    // into the output register, so the writer can refill it while that sample
    // is still waiting for its handshake; this keeps back-to-back frames bubble-free.
    always_comb begin
        raddr_c   = ((rd_state == R_IDLE) || (rd_cnt == CNT_LAST)) ? '0 : rd_cnt + LOG2N'(1);
        drain_c   = (rd_state == R_STREAM) && out_valid && out_ready && (rd_cnt == CNT_PEN);
        rd_word_c = rd_bank ? rdata1_c : rdata0_c;
    end

    fft_reorder_bank #(.LOG2N(LOG2N), .W(W)) u_bank0 (
        .clk      (clk),
        .rst      (rst),
        .we       (accept_c && !wr_bank),
        .waddr    (waddr_c),
        .wdata    ({in_r, in_i}),
        .set_full (wlast_c && !wr_bank),
        .clr_full (drain_c && !rd_bank),
        .raddr    (raddr_c),
        .rdata_c  (rdata0_c),
        .full     (full[0])
    );

    fft_reorder_bank #(.LOG2N(LOG2N), .W(W)) u_bank1 (
        .clk      (clk),
        .rst      (rst),
        .we       (accept_c && wr_bank),
        .waddr    (waddr_c),
        .wdata    ({in_r, in_i}),
        .set_full (wlast_c && wr_bank),
        .clr_full (drain_c && rd_bank),
        .raddr    (raddr_c),
        .rdata_c  (rdata1_c),
        .full     (full[1])
    );

    // Read FSM and output register; outputs hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state  <= R_IDLE;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (full[rd_bank]) begin
                        rd_state  <= R_STREAM;
                        rd_cnt    <= '0;
                        out_r     <= rd_word_c[W-1:WI];
                        out_i     <= rd_word_c[WI-1:0];
                        out_valid <= 1'b1;
                        out_sop   <= 1'b1;
                        out_eop   <= 1'b0;
                    end
                end
                R_STREAM: begin
                    if (out_valid && out_ready) begin
                        if (rd_cnt == CNT_LAST) begin
                            if (full[rd_bank]) begin
                                rd_cnt  <= '0;
                                out_r   <= rd_word_c[W-1:WI];
                                out_i   <= rd_word_c[WI-1:0];
                                out_sop <= 1'b1;
                                out_eop <= 1'b0;
                            end else begin
                                rd_state  <= R_IDLE;
                                out_valid <= 1'b0;
                                out_sop   <= 1'b0;
                                out_eop   <= 1'b0;
                            end
                        end else begin
                            rd_cnt  <= rd_cnt + LOG2N'(1);
                            out_r   <= rd_word_c[W-1:WI];
                            out_i   <= rd_word_c[WI-1:0];
                            out_sop <= 1'b0;
                            out_eop <= (rd_cnt == CNT_PEN);
                            if (rd_cnt == CNT_PEN) begin
                                rd_bank <= ~rd_bank;
                            end
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Scoreboard bench for fft_reorder_buffer (N=32): driver pushes expected
// natural-order frames, a negedge monitor compares every presented sample.
module tb_fft_reorder_buffer;

    localparam int LOG2N = 5;
    localparam int N     = 32;
    localparam int WR    = 10;
    localparam int WI    = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_sop = 1'b0;
    logic signed [WR-1:0] in_r = '0;
    logic signed [WI-1:0] in_i = '0;
    logic                 bypass = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic                 out_sop;
    logic                 out_eop;
    logic signed [WR-1:0] out_r;
    logic signed [WI-1:0] out_i;
    logic                 err_sync;

    always #5 clk = ~clk;

    fft_reorder_buffer #(.LOG2N(LOG2N), .WR(WR), .WI(WI)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_r      (in_r),
        .in_i      (in_i),
        .bypass    (bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_r     (out_r),
        .out_i     (out_i),
        .err_sync  (err_sync)
    );

    typedef struct {
        int re;
        int im;
        bit sop;
        bit eop;
    } exp_t;

    exp_t q[$];
    exp_t e;

    // 5-bit reversal of 0..31, worked out by hand.
    int br5 [32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                     1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int hs_cnt    = 0;
    int err_cnt   = 0;
    int stall_cnt = 0;
    int acc_cyc   = 0;
    int lat_cyc   = 0;
    bit lat_armed = 1'b0;
    bit gap_on    = 1'b0;
    bit have_prev = 1'b0;
    int prev_cyc  = 0;
    int gap_cnt   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compare each presented sample with the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (err_sync) err_cnt++;
            if (lat_armed && out_valid) begin
                lat_cyc   = cyc;
                lat_armed = 1'b0;
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = q[0];
                    chk(out_ready ? "out_r" : "hold_r", int'(out_r), e.re);
                    chk(out_ready ? "out_i" : "hold_i", int'(out_i), e.im);
                    chk(out_ready ? "out_sop" : "hold_sop", int'(out_sop), int'(e.sop));
                    chk(out_ready ? "out_eop" : "hold_eop", int'(out_eop), int'(e.eop));
                    if (out_ready) begin
                        void'(q.pop_front());
                        hs_cnt++;
                        if (gap_on) begin
                            if (have_prev && cyc != prev_cyc + 1) gap_cnt++;
                            prev_cyc  = cyc;
                            have_prev = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_sample(input int re, input int im, input bit sop, input bit byp);
        int guard = 0;
        in_valid = 1'b1;
        in_r     = WR'(re);
        in_i     = WI'(im);
        in_sop   = sop;
        bypass   = byp;
        while (!in_ready && guard < 300) begin
            stall_cnt++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 300) chk("in_ready_timeout", 0, 1);
        @(negedge clk);
        acc_cyc = cyc;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    // Frame f carries re = 32*f + k, im = f - k for input index k. Bypass is
    // driven to the requested value only on the first sample to prove it is latched.
    task automatic send_frame(input int f, input bit byp, input bit first_sop);
        for (int k = 0; k < N; k++)
            send_sample(32 * f + k, f - k, (k == 0) ? first_sop : 1'b0, (k == 0) ? byp : !byp);
    endtask

    task automatic push_frame(input int f, input bit byp);
        exp_t x;
        int k;
        for (int j = 0; j < N; j++) begin
            k     = byp ? j : br5[5'(j)];
            x.re  = 32 * f + k;
            x.im  = f - k;
            x.sop = (j == 0);
            x.eop = (j == N - 1);
            q.push_back(x);
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_left", q.size(), 0);
    endtask

    initial begin
        int e0;
        int h0;
        int g;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sop_eop", int'({out_sop, out_eop}), 0);
        chk("rst_out_data", int'({out_r, out_i}), 0);
        chk("rst_err_sync", int'(err_sync), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Bit-reversed frame, plus input-to-output latency.
        lat_armed = 1'b1;
        push_frame(0, 1'b0);
        send_frame(0, 1'b0, 1'b1);
        idle();
        drain(200);
        chk("latency_edges", lat_cyc - acc_cyc, 1);

        // Bypass frame.
        push_frame(1, 1'b1);
        send_frame(1, 1'b1, 1'b1);
        idle();
        drain(200);

        // Four back-to-back frames; frame 4 starts without in_sop.
        stall_cnt = 0;
        gap_cnt   = 0;
        have_prev = 1'b0;
        gap_on    = 1'b1;
        h0        = hs_cnt;
        for (int f = 2; f < 6; f++) begin
            push_frame(f, 1'b0);
            send_frame(f, 1'b0, f != 4);
        end
        idle();
        drain(300);
        gap_on = 1'b0;
        chk("b2b_in_ready_low", stall_cnt, 0);
        chk("b2b_output_gaps", gap_cnt, 0);
        chk("b2b_output_count", hs_cnt - h0, 4 * N);
        chk("no_err_sync_yet", err_cnt, 0);

        // Downstream stall for 70 cycles while three frames arrive.
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        fork
            begin
                push_frame(6, 1'b0);
                send_frame(6, 1'b0, 1'b1);
                push_frame(7, 1'b0);
                send_frame(7, 1'b0, 1'b1);
                chk("stall_in_ready_after_64", int'(in_ready), 0);
                push_frame(8, 1'b0);
                send_frame(8, 1'b0, 1'b1);
                idle();
            end
            begin
                repeat (70) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain(300);

        // Resync: in_sop at sample 10 discards the partial frame.
        e0 = err_cnt;
        for (int k = 0; k < 10; k++)
            send_sample(32 * 9 + k, 9 - k, k == 0, 1'b0);
        push_frame(10, 1'b0);
        send_frame(10, 1'b0, 1'b1);
        idle();
        drain(200);
        chk("resync_err_pulses", err_cnt - e0, 1);

        // Reset in the middle of an output frame with a partial input frame pending.
        e0 = err_cnt;
        push_frame(11, 1'b0);
        send_frame(11, 1'b0, 1'b1);
        idle();
        h0 = hs_cnt;
        g  = 0;
        while (hs_cnt - h0 < 10 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("pre_reset_outputs_timeout", int'(g >= 200), 0);
        for (int k = 0; k < 5; k++)
            send_sample(32 * 12 + k, 12 - k, k == 0, 1'b0);
        idle();
        @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("after_rst_out_valid", int'(out_valid), 0);
        chk("after_rst_in_ready", int'(in_ready), 1);
        chk("after_rst_out_sop", int'(out_sop), 0);
        rst = 1'b0;
        push_frame(13, 1'b0);
        send_frame(13, 1'b0, 1'b0);
        idle();
        drain(200);
        chk("post_reset_err_pulses", err_cnt - e0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000, required finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
